// File: rtl/bs_fixed_pkg.sv
// bs_fixed_pkg - shared fixed-point definitions for the Black-Scholes datapath.
//   DATA_W/FRAC_W/ONE : default Q6.10 format constants
//   fixed_t           : default signed fixed-point word
//   sat_fixed()       : clamp an integer into [lo, hi] (used by sqrt/exp/ln/norm-CDF)
//   sqrt_round()      : round(sqrt(v)) for non-negative v, used for elaboration-time tables
package bs_fixed_pkg;

   localparam int DATA_W = 16;
   localparam int FRAC_W = 10;
   localparam int ONE    = 1 << FRAC_W;

   typedef logic signed [DATA_W-1:0] fixed_t;

   function automatic int sat_fixed(input int v, input int lo, input int hi);
      if (v < lo)      return lo;
      else if (v > hi) return hi;
      else             return v;
   endfunction

   // Bitwise integer sqrt, then round-to-nearest: v > r*r + r  <=>  sqrt(v) > r + 0.5
   function automatic longint sqrt_round(input longint v);
      longint r;
      longint t;
      r = 0;
      for (int b = 30; b >= 0; b--) begin
         t = r | (longint'(1) << b);
         if (t * t <= v) r = t;
      end
      if (v - r * r > r) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/sqrt_lut_rom.sv
// sqrt_lut_rom - square-root table with registered read ports.
//   rom[i] = round(sqrt(i * 2^STEP_W / 2^FRAC_W) * 2^FRAC_W), i = 0 .. 2^ADDR_W
//   clk    : clock
//   en     : read-register enable (pipeline advance)
//   addr_a : port A address, y_a : port A registered data
//   addr_b : port B address, y_b : port B registered data (only with SQRT_INTERP_EN)
// Macro: SQRT_INTERP_EN adds the second read port.
module sqrt_lut_rom #(
   parameter int ADDR_W = 9,
   parameter int STEP_W = 5,
   parameter int FRAC_W = 10,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              en,
   input  logic [ADDR_W:0]   addr_a,
   output logic [DATA_W-1:0] y_a
`ifdef SQRT_INTERP_EN
   ,
   input  logic [ADDR_W:0]   addr_b,
   output logic [DATA_W-1:0] y_b
`endif
);
   import bs_fixed_pkg::*;

   localparam int DEPTH = (1 << ADDR_W) + 1;

   logic [DATA_W-1:0] rom [DEPTH];

   for (genvar i = 0; i < DEPTH; i++) begin : g_rom
      assign rom[i] = DATA_W'(sqrt_round(longint'(i) << (STEP_W + FRAC_W)));
   end

   always_ff @(posedge clk) begin
      if (en) begin
         y_a <= rom[addr_a];
`ifdef SQRT_INTERP_EN
         y_b <= rom[addr_b];
`endif
      end
   end

endmodule

// File: rtl/sqrt_pipe.sv
// sqrt_pipe - 3-stage pipelined fixed-point square root with valid/ready.
//   S0 clamp/split, S1 registered ROM read, S2 interpolate (or pass y0).
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : input handshake; in_ready = !out_valid || out_ready
//   x_in                : signed operand, Q(DATA_W-FRAC_W).FRAC_W
//   out_valid/out_ready : output handshake
//   sqrt_out            : sqrt(x), same Q format, non-negative
//   out_sat             : operand was negative or above 2^X_MAX_LOG2
// Macro: SQRT_INTERP_EN enables linear interpolation in S2.
module sqrt_pipe #(
   parameter int DATA_W     = bs_fixed_pkg::DATA_W,
   parameter int FRAC_W     = bs_fixed_pkg::FRAC_W,
   parameter int X_MAX_LOG2 = 14,
   parameter int ADDR_W     = 9
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] x_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic        [DATA_W-1:0] sqrt_out,
   output logic                     out_sat
);
   import bs_fixed_pkg::*;

   localparam int STEP_W = X_MAX_LOG2 - ADDR_W;
   localparam int XMAX   = 1 << X_MAX_LOG2;

   if (STEP_W < 1) begin : g_bad_step
      $error("sqrt_pipe: X_MAX_LOG2 must exceed ADDR_W");
   end

   logic              en;
   logic              v0, v1;
   logic              s0, s1;
   logic [ADDR_W:0]   addr0;
   logic [DATA_W-1:0] y0;
   logic [DATA_W-1:0] res;
`ifdef SQRT_INTERP_EN
   localparam logic [ADDR_W:0] ADDR_TOP = (ADDR_W+1)'(1 << ADDR_W);
   logic [STEP_W-1:0]        frac0, frac1;
   logic [ADDR_W:0]          addr0_nx;
   logic [DATA_W-1:0]        y1;
   logic [DATA_W-1:0]        diff;
   logic [DATA_W+STEP_W-1:0] prod;
`endif

   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   // S0: clamp and split into table address / in-segment fraction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v0    <= 1'b0;
         s0    <= 1'b0;
         addr0 <= '0;
`ifdef SQRT_INTERP_EN
         frac0 <= '0;
`endif
      end else if (en) begin
         v0    <= in_valid;
         s0    <= (x_in < 0) || (int'(x_in) > XMAX);
         addr0 <= (ADDR_W+1)'(sat_fixed(int'(x_in), 0, XMAX) >> STEP_W);
`ifdef SQRT_INTERP_EN
         frac0 <= STEP_W'(sat_fixed(int'(x_in), 0, XMAX));
`endif
      end
   end

`ifdef SQRT_INTERP_EN
   // At the top entry frac is always 0, so reusing the same entry is harmless
   assign addr0_nx = (addr0 == ADDR_TOP) ? addr0 : addr0 + 1'b1;
`endif

   // S1: table read registers live inside the ROM
   sqrt_lut_rom #(
      .ADDR_W (ADDR_W),
      .STEP_W (STEP_W),
      .FRAC_W (FRAC_W),
      .DATA_W (DATA_W)
   ) u_rom (
      .clk    (clk),
      .en     (en),
      .addr_a (addr0),
      .y_a    (y0)
`ifdef SQRT_INTERP_EN
      ,
      .addr_b (addr0_nx),
      .y_b    (y1)
`endif
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1    <= 1'b0;
         s1    <= 1'b0;
`ifdef SQRT_INTERP_EN
         frac1 <= '0;
`endif
      end else if (en) begin
         v1    <= v0;
         s1    <= s0;
`ifdef SQRT_INTERP_EN
         frac1 <= frac0;
`endif
      end
   end

   // S2: y0 + round((y1 - y0) * frac / 2^STEP_W); the table is monotonic so diff >= 0
   always_comb begin
`ifdef SQRT_INTERP_EN
      diff = y1 - y0;
      prod = diff * frac1 + (DATA_W+STEP_W)'(1 << (STEP_W - 1));
      res  = y0 + DATA_W'(prod >> STEP_W);
`else
      res  = y0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_sat   <= 1'b0;
         sqrt_out  <= '0;
      end else if (en) begin
         out_valid <= v1;
         out_sat   <= s1;
         sqrt_out  <= res;
      end
   end

endmodule

// File: tb/tb_sqrt_pipe.sv
module tb_sqrt_pipe;

   localparam int XMAX = 16384;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic signed [15:0] x_in;
   logic               out_valid;
   logic               out_ready;
   logic        [15:0] sqrt_out;
   logic               out_sat;

   int checks   = 0;
   int failures = 0;
   int xs[$];

   always #5 clk = ~clk;

   sqrt_pipe #(
      .DATA_W     (16),
      .FRAC_W     (10),
      .X_MAX_LOG2 (14),
      .ADDR_W     (9)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_in      (x_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sqrt_out  (sqrt_out),
      .out_sat   (out_sat)
   );

   // Table point i sits at x = i*32 raw units: round(sqrt(x/1024)*1024)
   function automatic int tbl(input int i);
      return $rtoi($sqrt(real'(i) * 32.0 / 1024.0) * 1024.0 + 0.5);
   endfunction

   function automatic int model(input int x);
      int xc, a, f, lo;
      xc = (x < 0) ? 0 : (x > XMAX) ? XMAX : x;
      a  = xc / 32;
      f  = xc % 32;
      lo = tbl(a);
`ifdef SQRT_INTERP_EN
      return lo + ((tbl((a < 512) ? a + 1 : 512) - lo) * f + 16) / 32;
`else
      if (f < 0) return 0;  // f is never negative; keeps f referenced in this build
      return lo;
`endif
   endfunction

   function automatic bit model_sat(input int x);
      return (x < 0) || (x > XMAX);
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; x_in = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (sqrt_out !== 16'd0) begin failures++; $display("FAIL reset_sqrt_out got=%0d exp=0", sqrt_out); end
      checks++; if (out_sat !== 1'b0) begin failures++; $display("FAIL reset_out_sat got=%b exp=0", out_sat); end
      rst_n = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      @(posedge clk); #1;
   endtask

   task automatic single(input int x, input int exp_o, input bit exp_s, input string nm);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      x_in      = 16'(x);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL %s_early got=%b exp=0", nm, out_valid); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL %s_valid got=%b exp=1", nm, out_valid); end
      checks++; if (sqrt_out !== 16'(exp_o)) begin failures++; $display("FAIL %s_value got=%0d exp=%0d", nm, sqrt_out, exp_o); end
      checks++; if (out_sat !== exp_s) begin failures++; $display("FAIL %s_sat got=%b exp=%b", nm, out_sat, exp_s); end
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      single(4096, 2048, 1'b0, "x4096");
      single(16384, 4096, 1'b0, "x16384");
      single(0, 0, 1'b0, "x0");
`ifdef SQRT_INTERP_EN
      single(1040, 1032, 1'b0, "x1040");
`else
      single(1040, 1024, 1'b0, "x1040");
`endif
      single(-5, 0, 1'b1, "xneg5");
      single(20000, 4096, 1'b1, "x20000");
   endtask

   // Streams xs through the DUT with random input gaps and output stalls
   task automatic stream(input int stall_pct, input int gap_pct, input bit bound_chk, input string nm);
      int n, idx, got, cyc, x, exp_o, err;
      bit stalled, held_sat;
      logic [15:0] held;
      int q[$];
      n = xs.size(); idx = 0; got = 0; cyc = 0; stalled = 1'b0; held = '0; held_sat = 1'b0;
      while (got < n && cyc < n * 20 + 200) begin
         in_valid  = (idx < n) && ($urandom_range(99) >= gap_pct);
         x_in      = in_valid ? 16'(xs[idx]) : 16'($urandom);
         out_ready = ($urandom_range(99) >= stall_pct);
         #1;
         if (stalled) begin
            checks++;
            if (out_valid !== 1'b1 || sqrt_out !== held || out_sat !== held_sat) begin
               failures++;
               $display("FAIL %s_hold got=%b/%0d/%b exp=1/%0d/%b", nm, out_valid, sqrt_out, out_sat, held, held_sat);
            end
         end
         if (out_valid && !out_ready) begin
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL %s_stall_in_ready got=%b exp=0", nm, in_ready); end
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               checks++; failures++;
               $display("FAIL %s_extra got=%0d exp=none", nm, sqrt_out);
            end else begin
               x = q.pop_front();
               exp_o = model(x);
               checks++;
               if (sqrt_out !== 16'(exp_o) || out_sat !== model_sat(x)) begin
                  failures++;
                  $display("FAIL %s_result x=%0d got=%0d/%b exp=%0d/%b", nm, x, sqrt_out, out_sat, exp_o, model_sat(x));
               end
               if (bound_chk && x >= 256) begin
                  err = int'(sqrt_out) - $rtoi($sqrt(real'(x) * 1024.0) + 0.5);
                  checks++;
                  if (err > 2 || err < -2) begin
                     failures++;
                     $display("FAIL %s_err_bound x=%0d got=%0d exp=|err|<=2", nm, x, err);
                  end
               end
            end
            got++;
         end
         if (in_valid && in_ready) begin
            q.push_back(xs[idx]);
            idx++;
         end
         stalled  = out_valid && !out_ready;
         held     = sqrt_out;
         held_sat = out_sat;
         @(posedge clk); #1;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (got != n) begin failures++; $display("FAIL %s_timeout got=%0d exp=%0d", nm, got, n); end
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back_ramp();
      xs.delete();
      for (int x = 0; x <= XMAX; x += 32) xs.push_back(x);
      stream(30, 0, 1'b0, "ramp");
   endtask

   task automatic test_random();
      xs.delete();
      xs.push_back(16385); xs.push_back(-1); xs.push_back(-32768); xs.push_back(32767);
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(3) == 0) xs.push_back(int'($signed(16'($urandom))));
         else                        xs.push_back(int'($urandom_range(XMAX)));
      end
      stream(25, 20, 1'b0, "random");
   endtask

`ifdef SQRT_INTERP_EN
   task automatic test_sweep();
      xs.delete();
      for (int x = 0; x <= XMAX; x++) xs.push_back(x);
      stream(0, 0, 1'b1, "sweep");
   endtask
`endif

   task automatic test_reset_midflight();
      int seen;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         x_in     = (i == 0) ? 16'sd20000 : 16'sd4096;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL midrst_pre_valid got=%b exp=1", out_valid); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
      checks++; if (sqrt_out !== 16'd0) begin failures++; $display("FAIL midrst_sqrt_out got=%0d exp=0", sqrt_out); end
      checks++; if (out_sat !== 1'b0) begin failures++; $display("FAIL midrst_out_sat got=%b exp=0", out_sat); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      checks++; if (seen != 0) begin failures++; $display("FAIL midrst_stale got=%0d exp=0", seen); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back_ramp();
      test_random();
`ifdef SQRT_INTERP_EN
      test_sweep();
`endif
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
